sincos_arbiter: RTL and testbench
=================================

# sincos_arbiter

Shares one `sine_cosine_top` unit among `NREQ` requesters. Each requester presents an IEEE-754 double angle with a valid/ready handshake. The arbiter grants requesters in round-robin order and holds the core's angle and `enable` steady until the core pulses `valid`. It then returns the sine/cosine pair, tagged with the requester ID, on a single response channel. The block sits between the scheduler's angle producers and the shared core, and is the only driver of the core's `angle_64` and `enable`.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `ID_W`, 2, requester-ID width, equal to clog2(`NREQ`)
- `TIMEOUT`, 32, maximum RUN cycles without `core_valid` before an error response

- `clk`  in  1  clock, rising edge
- `srstn`  in  1  reset, asynchronous and active-low
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_angle`  in  64*NREQ  requester i's angle at bits [64i+63:64i]
- `core_angle`  out  64  to core `angle_64`
- `core_enable`  out  1  to core `enable`
- `core_sin`, `core_cos`  in  64 each  from core `sine_value` / `cosine_value`
- `core_valid`  in  1  from core `valid`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  ID_W  granted requester index
- `rsp_sin`, `rsp_cos`  out  64 each  captured results
- `rsp_err`  out  1  response produced by timeout
- `busy`  out  1  state is not IDLE

## Operation
- The FSM has three states: IDLE, RUN and RESP.
- **IDLE**
  - When any `req_valid` bit is set, select grant g: the first set bit searching upward, with wrap-around, from `last_grant+1`.
  - Drive `req_ready[g]=1` combinationally in the same cycle; the handshake completes that cycle.
  - Latch `req_angle[g]` into the angle register, latch g into the ID register, set `last_grant=g`, clear the timeout counter, and go to RUN.
  - If no `req_valid` bit is set, stay in IDLE.
- **RUN**
  - `core_enable=1`. `core_angle` carries the latched angle and stays stable throughout RUN.
  - The timeout counter increments every RUN cycle.
  - When `core_valid=1`: capture `core_sin`/`core_cos` into the response registers, set `rsp_err=0`, and go to RESP.
  - Else, when the counter reaches `TIMEOUT`: set the response registers to 0, set `rsp_err=1`, and go to RESP.
  - If `core_valid` and timeout occur in the same cycle, the valid result wins.
- **RESP**
  - `rsp_valid=1` and `core_enable=0`. Dropping `enable` clears the core's internal counter, so an aborted operation leaves the core clean.
  - All `rsp_*` outputs hold stable until `rsp_ready=1`; then go to IDLE.
- `req_ready` is 0 in RUN and RESP. A new grant requires one IDLE cycle, which guarantees `enable` is low for at least 2 cycles between operations.
- `core_valid` is ignored outside RUN.
- The timeout counter width is clog2(`TIMEOUT`+1); it saturates and never wraps.

## Timing
- **Reset values:** state=IDLE; `req_ready`=0, `core_enable`=0, `core_angle`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sin`=0, `rsp_cos`=0, `rsp_err`=0, `busy`=0; `last_grant`=`NREQ`-1, so requester 0 has first priority.
- **Reset mid-operation:** asserting `srstn` low in any state returns immediately to the reset values. `core_enable` falls asynchronously, and any in-flight request is dropped without a response.
- **Latency:** let cycle 0 be the handshake cycle. RUN spans cycles 1..N, where N is the cycle in which `core_valid` is high. With the existing core (25 enabled cycles, then a registered `valid`), `core_valid` is seen in cycle 26 and `rsp_valid` rises in cycle 27.
- The design must rely only on `core_valid` and never on a fixed latency.
- **Throughput:** one response per (RUN length + RESP cycles + 1 IDLE) cycles; 28 cycles with `rsp_ready` tied high.
- All outputs except `req_ready` are registered.

## Test plan
- **Single request:** requester 2 sends angle 0x3FF0000000000000 (1.0) with `rsp_ready`=1, against a core model that returns sin 0x3FEAED548F090CEE and cos 0x3FE14A280FB5068C with `valid` 26 cycles after `enable` rises. Required: `req_ready`=0b0100 in cycle 0, `core_enable` high in cycles 1..26, `rsp_valid` in cycle 27 with `rsp_id`=2, exact sin/cos values, and `rsp_err`=0.
- **Round robin:** all four `req_valid` held high continuously for 6 grants. Required grant order 0,1,2,3,0,1, and never two `req_ready` bits set at once.
- **Backpressure:** `rsp_ready` held low for 10 cycles after `rsp_valid` rises. Required: `rsp_*` stable, `core_enable`=0, `req_ready`=0 throughout; IDLE one cycle after `rsp_ready` rises.
- **Timeout:** the core model never asserts `valid`, with `TIMEOUT`=32. Required: `rsp_valid` with `rsp_err`=1, `rsp_sin`=0, `rsp_cos`=0 after 32 RUN cycles. The next request must then complete normally.
- **Boundary collision:** `core_valid` arrives in the same cycle the timeout counter reaches `TIMEOUT`. Required: `rsp_err`=0 with the captured values. `core_valid` pulses injected in IDLE and RESP must be ignored.
- **Reset mid-RUN:** `srstn` pulsed low in cycle 10 of RUN. Required: all outputs go to 0 immediately and no response is produced. After release, requester 0 wins if requesters 0 and 3 are both pending.

Source files
------------

// File: rtl/sincos_arbiter.sv
// sincos_arbiter
//   Shares one sine_cosine_top core among NREQ angle requesters. Requests are
//   granted round-robin, the granted angle is held on the core with enable
//   high until the core reports valid (or a timeout expires), and the result
//   is returned on a single response channel tagged with the requester index.
//
// Ports
//   clk, srstn              clock (rising edge), async active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot or zero)
//   req_angle               requester i's IEEE-754 angle at [64i+63:64i]
//   core_angle/core_enable  drive the shared core's angle_64 / enable
//   core_sin/core_cos/core_valid  core results
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_sin/rsp_cos/rsp_err  response payload (err = timed out)
//   busy                    FSM is not IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation; grant the next pending requester (round robin)
// RUN   | core enabled with the latched angle, waiting for core_valid
// RESP  | result (or timeout error) presented until rsp_ready

module sincos_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 srstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_angle,
    output logic [63:0]          core_angle,
    output logic                 core_enable,
    input  logic [63:0]          core_sin,
    input  logic [63:0]          core_cos,
    input  logic                 core_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [63:0]          rsp_sin,
    output logic [63:0]          rsp_cos,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [63:0]       angle_q, angle_d;
    logic [63:0]       sin_q, sin_d;
    logic [63:0]       cos_q, cos_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              enable_q, enable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              timeout_hit;

    // First set bit searching upward from last+1 with wrap-around.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] vld,
                                              input logic [ID_W-1:0] last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (vld[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        {grant_found, grant_idx} = rr_pick(req_valid, last_q);
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        angle_d     = angle_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        req_ready   = '0;
        timeout_hit = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    // Gated by srstn so ready reads zero while reset is held.
                    req_ready = srstn ? (NREQ'(1) << grant_idx) : '0;
                    angle_d   = req_angle[64*int'(grant_idx) +: 64];
                    id_d      = grant_idx;
                    last_d    = grant_idx;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                timeout_hit = (cnt_d == CNT_MAX);
                // A valid result takes priority over a coincident timeout.
                if (core_valid) begin
                    sin_d   = core_sin;
                    cos_d   = core_cos;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    sin_d   = '0;
                    cos_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        enable_d    = (state_d == S_RUN);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q     <= S_IDLE;
            last_q      <= ID_W'(NREQ - 1);
            id_q        <= '0;
            angle_q     <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            angle_q     <= angle_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            enable_q    <= enable_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign core_angle  = angle_q;
    assign core_enable = enable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_sin     = sin_q;
    assign rsp_cos     = cos_q;
    assign rsp_err     = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sincos_arbiter.sv
// Testbench for sincos_arbiter: randomized requesters, a behavioural core
// model, and a scoreboard monitor that checks grants, RUN behaviour and
// responses against expectations derived from the arbitration rules.

module tb_sincos_arbiter;

    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 32;

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] SIN1 = 64'h3FEAED548F090CEE;
    localparam logic [63:0] COS1 = 64'h3FE14A280FB5068C;

    logic                clk = 1'b0;
    logic                srstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [64*NREQ-1:0]  req_angle;
    logic [63:0]         core_angle;
    logic                core_enable;
    logic [63:0]         core_sin, core_cos;
    logic                core_valid;
    logic                rsp_valid, rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_sin, rsp_cos;
    logic                rsp_err;
    logic                busy;

    sincos_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .srstn      (srstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_angle  (req_angle),
        .core_angle (core_angle),
        .core_enable(core_enable),
        .core_sin   (core_sin),
        .core_cos   (core_cos),
        .core_valid (core_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sin    (rsp_sin),
        .rsp_cos    (rsp_cos),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Core result functions: real values for 1.0, a cheap bijection otherwise.
    function automatic logic [63:0] f_sin(input logic [63:0] a);
        if (a == ONE) return SIN1;
        return {a[31:0], a[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] f_cos(input logic [63:0] a);
        if (a == ONE) return COS1;
        return a ^ 64'hFEDC_BA98_7654_3210;
    endfunction

    // ---------------- core model ----------------
    // cur_valid_at: RUN cycle (1-based) in which valid is asserted; 0 = never.
    int cur_valid_at = 26;
    bit glitch_en    = 1'b0;
    int en_cnt       = 0;

    initial begin
        core_valid = 1'b0;
        core_sin   = '0;
        core_cos   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (core_enable) en_cnt++;
            else             en_cnt = 0;
            if (core_enable) core_valid = (en_cnt == cur_valid_at);
            else             core_valid = glitch_en && ($urandom_range(0, 2) == 0);
            core_sin = f_sin(core_angle);
            core_cos = f_cos(core_angle);
        end
    end

    // ---------------- requester / response driver ----------------
    int rate [NREQ];
    int rsp_mode = 0;   // 0: ready tied high, 1: random, 2: sequencer-controlled

    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_ready & req_valid;
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] || !req_valid[i]) begin
                if ($urandom_range(0, 99) < rate[i]) begin
                    req_valid[i] = 1'b1;
                    req_angle[64*i +: 64] = {$urandom, $urandom};
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (rsp_mode == 0)      rsp_ready = 1'b1;
        else if (rsp_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic force_req(input int i, input logic [63:0] a);
        req_valid[i] = 1'b1;
        req_angle[64*i +: 64] = a;
    endtask

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct {
        int          id;
        logic [63:0] angle;
        logic [63:0] sin_v;
        logic [63:0] cos_v;
        logic        err;
        int          hs_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t e;
    int   grant_log[$];
    int   m_last     = NREQ - 1;
    bit   m_busy     = 1'b0;
    bit   m_rsp_prev = 1'b0;
    int   cyc        = 0;
    int   n_resp     = 0;
    bit   va_rand    = 1'b0;
    int   va_fixed   = 26;
    int   g;
    int   va;
    logic [63:0]     h_sin, h_cos;
    logic [ID_W-1:0] h_id;
    logic            h_err;

    function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
        int order[$];
        for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic int pick_valid_at();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return 26;
            3:       return TIMEOUT;
            4:       return TIMEOUT + 1;
            default: return int'($urandom_range(2, 40));
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!srstn) begin
            m_rsp_prev = 1'b0;
        end else if (!m_busy) begin
            chk("idle_busy", busy, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            if (req_valid != '0) begin
                g = model_pick(req_valid, m_last);
                chk("grant", req_ready, 64'(1) << g);
                va           = va_rand ? pick_valid_at() : va_fixed;
                cur_valid_at = va;
                e.id     = g;
                e.angle  = req_angle[64*g +: 64];
                e.err    = !(va >= 1 && va <= TIMEOUT);
                e.sin_v  = e.err ? 64'd0 : f_sin(e.angle);
                e.cos_v  = e.err ? 64'd0 : f_cos(e.angle);
                e.hs_cyc = cyc;
                e.lat    = e.err ? TIMEOUT + 1 : va + 1;
                sb.push_back(e);
                grant_log.push_back(g);
                m_last = g;
                m_busy = 1'b1;
                cur    = e;
            end else begin
                chk("idle_no_ready", req_ready, 0);
            end
        end else begin
            chk("busy_no_ready", req_ready, 0);
            chk("busy_flag", busy, 1);
            if (!rsp_valid) begin
                chk("run_enable", core_enable, 1);
                chk("run_angle", core_angle, cur.angle);
                chk("run_not_late", (cyc - cur.hs_cyc) < cur.lat, 1);
            end else begin
                chk("resp_enable_low", core_enable, 0);
                if (!m_rsp_prev) begin
                    e = sb.pop_front();
                    chk("rsp_latency", cyc - e.hs_cyc, e.lat);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_sin", rsp_sin, e.sin_v);
                    chk("rsp_cos", rsp_cos, e.cos_v);
                    chk("rsp_err", rsp_err, e.err);
                    h_id  = rsp_id;
                    h_sin = rsp_sin;
                    h_cos = rsp_cos;
                    h_err = rsp_err;
                end else begin
                    chk("hold_id", rsp_id, h_id);
                    chk("hold_sin", rsp_sin, h_sin);
                    chk("hold_cos", rsp_cos, h_cos);
                    chk("hold_err", rsp_err, h_err);
                end
                if (rsp_ready) begin
                    m_busy     = 1'b0;
                    m_rsp_prev = 1'b0;
                    n_resp++;
                end else begin
                    m_rsp_prev = 1'b1;
                end
            end
        end
    end

    // ---------------- sequencer helpers ----------------
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_core_enable"}, core_enable, 0);
        chk({tag, "_core_angle"}, core_angle, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_sin"}, rsp_sin, 0);
        chk({tag, "_rsp_cos"}, rsp_cos, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_busy     = 1'b0;
        m_rsp_prev = 1'b0;
        m_last     = NREQ - 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        srstn = 1'b0;
        #1;
        chk_reset_outputs("reset");
        model_reset();
        @(posedge clk);
        #2;
        srstn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((req_valid != '0 || m_busy) && k < budget) begin
            step();
            k++;
        end
        chk("drain_done", (req_valid == '0) && !m_busy, 1);
    endtask

    // ---------------- sequencer ----------------
    int base;
    int resp_before;
    int k;

    initial begin
        srstn     = 1'b0;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;
        foreach (rate[i]) rate[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(posedge clk);
        #2;
        srstn = 1'b1;
        step();

        // Single request from requester 2 with angle 1.0
        resp_before = n_resp;
        force_req(2, ONE);
        drain(100);
        chk("single_count", n_resp, resp_before + 1);

        // Round robin with all requesters continuously valid
        do_reset();
        base = grant_log.size();
        foreach (rate[i]) begin
            rate[i] = 100;
            force_req(i, {$urandom, $urandom});
        end
        k = 0;
        while (grant_log.size() < base + 6 && k < 400) begin
            step();
            k++;
        end
        foreach (rate[i]) rate[i] = 0;
        drain(400);
        chk("rr_grants", grant_log.size() >= base + 6, 1);
        if (grant_log.size() >= base + 6) begin
            for (int j = 0; j < 6; j++) chk("rr_order", grant_log[base + j], j % NREQ);
        end

        // Backpressure: hold rsp_ready low 10 cycles with another request pending
        rsp_mode  = 2;
        rsp_ready = 1'b0;
        force_req(1, {$urandom, $urandom});
        force_req(3, {$urandom, $urandom});
        k = 0;
        while (!rsp_valid && k < 100) begin
            step();
            k++;
        end
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (10) step();
        rsp_ready = 1'b1;
        rsp_mode  = 0;
        drain(200);

        // Timeout, then a normal request
        va_fixed = 0;
        force_req(0, {$urandom, $urandom});
        drain(100);
        va_fixed = 26;
        force_req(1, {$urandom, $urandom});
        drain(100);

        // Boundary collision and neighbours, with stray core_valid pulses
        glitch_en = 1'b1;
        rsp_mode  = 1;
        va_fixed  = TIMEOUT;
        force_req(2, {$urandom, $urandom});
        drain(200);
        va_fixed = TIMEOUT - 1;
        force_req(3, {$urandom, $urandom});
        drain(200);
        va_fixed = TIMEOUT + 1;
        force_req(0, {$urandom, $urandom});
        drain(200);

        // Random traffic
        va_rand     = 1'b1;
        resp_before = n_resp;
        foreach (rate[i]) rate[i] = 30;
        k = 0;
        while (n_resp < resp_before + 30 && k < 4000) begin
            step();
            k++;
        end
        chk("random_count", n_resp >= resp_before + 30, 1);
        foreach (rate[i]) rate[i] = 0;
        drain(400);

        // Reset in RUN cycle 10; afterwards 0 beats 3
        va_rand   = 1'b0;
        va_fixed  = 26;
        glitch_en = 1'b0;
        rsp_mode  = 0;
        resp_before = n_resp;
        force_req(1, {$urandom, $urandom});
        repeat (10) step();
        chk("pre_reset_enable", core_enable, 1);
        srstn = 1'b0;
        #1;
        chk_reset_outputs("midrun");
        model_reset();
        step();
        srstn = 1'b1;
        base = grant_log.size();
        force_req(3, {$urandom, $urandom});
        force_req(0, {$urandom, $urandom});
        drain(200);
        chk("post_reset_count", n_resp, resp_before + 2);
        chk("post_reset_grants", grant_log.size(), base + 2);
        if (grant_log.size() >= base + 2) begin
            chk("post_reset_first", grant_log[base], 0);
            chk("post_reset_second", grant_log[base + 1], 3);
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
